userport_joy_scan: RTL and testbench
====================================

# userport_joy_scan

Sequencer for the DB15 shift-register joystick adapter on the user port. It loads two cascaded 16-bit parallel-in/serial-out registers, clocks out 32 bits and accepts a frame only when two consecutive scans agree. It presents two active-high 16-bit joystick words to the core's joystick mux. It is the owner of JOY_CLK/JOY_LOAD while the DB15 user-port mode is selected.

## Interface
- DIV, 24: clk cycles per half-period of joy_clk and per load pulse (≥4).
- GAP, 480: idle clk cycles between scans (≥1).
- clk  in  1  system clock (40–50 MHz).
- sys_reset  in  1  asynchronous, active-low reset.
- enable  in  1  DB15 mode selected; low aborts any scan and idles the port.
- joy_data  in  1  serial data from the adapter; a pressed button reads 0; asynchronous.
- joy_clk  out  1  shift clock to the adapter; idles low.
- joy_load  out  1  parallel load, active low.
- joystick1  out  16  player 1 buttons, active high (bit map FEDCBAUDLR from bit 0 up).
- joystick2  out  16  player 2 buttons, active high.
- scan_done  out  1  one-cycle pulse at the end of every completed scan.
- frame_ok  out  1  one-cycle pulse when joystick1/2 were updated.

## Operation
- joy_data passes through a 2-flop synchronizer. All samples use the synchronized value.
- States:
  - IDLE: count GAP cycles, then go to LOAD.
  - LOAD: joy_load=0 for DIV cycles, then go to SHIFT with bit index k=0.
  - SHIFT_LO: joy_clk=0 for DIV cycles. On the last cycle, sample raw[k].
  - SHIFT_HI: joy_clk=1 for DIV cycles. If k=31, go to DONE; otherwise k++ and go to SHIFT_LO.
  - DONE: one cycle. Pulse scan_done, run the compare, return to IDLE.
- Bit order:
  - raw[15:0] → joystick1 = ~raw[15:0].
  - raw[31:16] → joystick2 = ~raw[31:16].
- Compare in DONE:
  - If prev_valid and raw==prev_raw: update both joystick words and pulse frame_ok.
  - Always: prev_raw←raw, prev_valid←1.
- enable low, any state: go to IDLE with counters cleared. Force joy_clk=0, joy_load=1, joystick1/2=0 and prev_valid=0. No pulses.
- enable rising: start from IDLE with the full GAP count.

## Timing
- Reset values: joy_clk=0, joy_load=1, joystick1=joystick2=0, scan_done=0, frame_ok=0, prev_valid=0, state IDLE, counters 0.
- Scan length after leaving IDLE: DIV + 64·DIV + 1 cycles. Period between scan_done pulses: GAP + 65·DIV + 1.
- joystick1/2 and frame_ok change in the cycle after DONE (registered), i.e. together with the scan_done pulse.
- Sample point: last clk cycle of each SHIFT_LO, with joy_clk low. The synchronizer adds 2 cycles of latency. The data must be stable for ≥3 cycles before the rising joy_clk edge; DIV≥4 guarantees this.
- joy_clk and joy_load are driven straight from registers (glitch-free). They are never low/high simultaneously in an overlapping way: joy_load returns high one DIV period before the first joy_clk rise.
- Reset asserted mid-scan: all outputs return to reset values immediately (async). Release restarts at IDLE.
- A press shorter than one scan period can be missed. A press must be seen in 2 consecutive scans to be reported.

## Structure
- Shared package `userport_pkg`:
  - State enum.
  - NBITS=32 constant.
  - DB15 bit-map constants (UP, DOWN, LEFT, RIGHT, A–F) used by the joystick mux.
- Sub-module `sync2` (2-flop synchronizer with async active-low reset, reset value 1) for joy_data.
- Counters:
  - Phase counter sized clog2(max(DIV,GAP)).
  - Bit index of 5 bits. It wraps only via the DONE transition and never counts past 31.

## Test plan
- Reset release, DIV=4, GAP=16, enable=1, adapter model with all bits 1:
  - First scan_done at cycle 16+260+1.
  - No frame_ok on the first scan.
  - Second scan gives frame_ok, with joystick1=joystick2=0x0000.
- Adapter drives raw=0xFFEF_FFFE (P1 R and P2 A pressed), steady for 2 scans → joystick1=0x0001, joystick2=0x0010, one frame_ok.
- Raw alternates between 0xFFFF_FFFE and 0xFFFF_FFFF on every scan → scan_done every period, frame_ok never, joysticks hold their last accepted value.
- Check pin waveforms:
  - joy_load low for exactly 4 cycles per scan.
  - Exactly 32 joy_clk rising edges per scan.
  - joy_clk never high while joy_load is low.
- enable dropped at bit 17 of a scan:
  - Next cycle: joy_clk=0, joy_load=1, joysticks=0, no pulses.
  - Re-enable: the next two full scans are needed before frame_ok.
- sys_reset pulsed low mid-SHIFT_HI → all outputs at reset values within the same cycle; the clean sequence restarts after release.

Source files
------------

// File: rtl/userport_pkg.sv
// Shared definitions for the DB15 user-port joystick adapter: scan states,
// frame width and the button bit positions used by the joystick mux.
package userport_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_DONE
    } scan_state_t;

    localparam int NBITS = 32;

    // Button positions inside each 16-bit joystick word (FEDCBAUDLR from bit 0 up)
    localparam int BIT_RIGHT = 0;
    localparam int BIT_LEFT  = 1;
    localparam int BIT_DOWN  = 2;
    localparam int BIT_UP    = 3;
    localparam int BIT_A     = 4;
    localparam int BIT_B     = 5;
    localparam int BIT_C     = 6;
    localparam int BIT_D     = 7;
    localparam int BIT_E     = 8;
    localparam int BIT_F     = 9;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous input; resets to 1 (released / idle level).
module sync2 (
    input  logic clk,
    input  logic sys_reset,
    input  logic async_data,
    output logic sync_data
);

    logic meta;

    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            meta      <= 1'b1;
            sync_data <= 1'b1;
        end else begin
            meta      <= async_data;
            sync_data <= meta;
        end
    end

endmodule

// File: rtl/userport_joy_scan.sv
// DB15 shift-register joystick sequencer: loads two cascaded 16-bit PISO registers,
// shifts out 32 bits and publishes the frame only after two identical scans.
module userport_joy_scan
    import userport_pkg::*;
#(
    parameter int DIV = 24,
    parameter int GAP = 480
) (
    input  logic        clk,
    input  logic        sys_reset,
    input  logic        enable,
    input  logic        joy_data,
    output logic        joy_clk,
    output logic        joy_load,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic        scan_done,
    output logic        frame_ok
);

    localparam int CNT_MAX = (DIV > GAP) ? DIV : GAP;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int BW      = $clog2(NBITS);

    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

    scan_state_t state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [BW-1:0]    bit_idx, bit_idx_n;
    logic             sample;
    logic             done;
    logic             data_sync;
    logic [NBITS-1:0] raw;
    logic [NBITS-1:0] prev_raw;
    logic             prev_valid;

    sync2 u_sync2 (
        .clk        (clk),
        .sys_reset  (sys_reset),
        .async_data (joy_data),
        .sync_data  (data_sync)
    );

    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        sample    = 1'b0;
        done      = 1'b0;
        if (!enable) begin
            state_n   = ST_IDLE;
            cnt_n     = '0;
            bit_idx_n = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cnt == GAP_LAST) begin
                        state_n = ST_LOAD;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                ST_LOAD: begin
                    if (cnt == DIV_LAST) begin
                        state_n   = ST_SHIFT_LO;
                        cnt_n     = '0;
                        bit_idx_n = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                ST_SHIFT_LO: begin
                    if (cnt == DIV_LAST) begin
                        sample  = 1'b1;
                        state_n = ST_SHIFT_HI;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                ST_SHIFT_HI: begin
                    if (cnt == DIV_LAST) begin
                        cnt_n = '0;
                        if (bit_idx == BIT_LAST) begin
                            state_n = ST_DONE;
                        end else begin
                            bit_idx_n = bit_idx + BW'(1);
                            state_n   = ST_SHIFT_LO;
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    done      = 1'b1;
                    state_n   = ST_IDLE;
                    cnt_n     = '0;
                    bit_idx_n = '0;
                end
                default: begin
                    state_n   = ST_IDLE;
                    cnt_n     = '0;
                    bit_idx_n = '0;
                end
            endcase
        end
    end

    // Pins are decoded from the next state so they are registered yet aligned with the state register
    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            joy_clk    <= 1'b0;
            joy_load   <= 1'b1;
            joystick1  <= '0;
            joystick2  <= '0;
            scan_done  <= 1'b0;
            frame_ok   <= 1'b0;
            raw        <= '1;
            prev_raw   <= '1;
            prev_valid <= 1'b0;
        end else begin
            joy_clk   <= (state_n == ST_SHIFT_HI);
            joy_load  <= (state_n != ST_LOAD);
            scan_done <= done;
            frame_ok  <= 1'b0;
            if (sample) begin
                raw[bit_idx] <= data_sync;
            end
            if (!enable) begin
                joystick1  <= '0;
                joystick2  <= '0;
                prev_valid <= 1'b0;
            end else if (done) begin
                prev_raw   <= raw;
                prev_valid <= 1'b1;
                if (prev_valid && (raw == prev_raw)) begin
                    joystick1 <= ~raw[15:0];
                    joystick2 <= ~raw[31:16];
                    frame_ok  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_userport_joy_scan.sv
// Bench for userport_joy_scan: behavioural PISO adapter, queue-based scoreboard
// fed by a frame-level reference model, and pin-waveform checks per scan.
module tb_userport_joy_scan;
    import userport_pkg::*;

    localparam int DIV    = 4;
    localparam int GAP    = 16;
    localparam int PERIOD = GAP + 65 * DIV + 1;
    localparam int BOUND  = 2000;

    typedef struct {
        logic        fok;
        logic [15:0] j1;
        logic [15:0] j2;
    } exp_t;

    logic        clk = 1'b0;
    logic        sys_reset;
    logic        enable;
    logic        joy_data;
    logic        joy_clk;
    logic        joy_load;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        scan_done;
    logic        frame_ok;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t        exp_q[$];
    logic [31:0] pattern = 32'hFFFF_FFFF;
    logic [31:0] shreg   = 32'hFFFF_FFFF;

    logic        m_prev_valid = 1'b0;
    logic [31:0] m_prev_raw   = 32'hFFFF_FFFF;
    logic [15:0] m_j1         = 16'h0;
    logic [15:0] m_j2         = 16'h0;

    int load_lo  = 0;
    int clk_rise = 0;
    bit overlap  = 1'b0;
    logic mon_last_clk = 1'b0;

    always #10 clk = ~clk;

    userport_joy_scan #(.DIV(DIV), .GAP(GAP)) dut (
        .clk       (clk),
        .sys_reset (sys_reset),
        .enable    (enable),
        .joy_data  (joy_data),
        .joy_clk   (joy_clk),
        .joy_load  (joy_load),
        .joystick1 (joystick1),
        .joystick2 (joystick2),
        .scan_done (scan_done),
        .frame_ok  (frame_ok)
    );

    // Two cascaded PISO registers: parallel load while joy_load is low, shift on joy_clk rise
    always @(negedge joy_load or posedge joy_clk) begin
        if (!joy_load) shreg = pattern;
        else           shreg = {1'b1, shreg[31:1]};
    end
    assign joy_data = shreg[0];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame-level model: a frame is accepted only when it repeats the previous completed scan
    task automatic predict(input logic [31:0] raw_v);
        exp_t e;
        e.fok = 1'b0;
        if (m_prev_valid && raw_v == m_prev_raw) begin
            m_j1  = ~raw_v[15:0];
            m_j2  = ~raw_v[31:16];
            e.fok = 1'b1;
        end
        e.j1 = m_j1;
        e.j2 = m_j2;
        m_prev_raw   = raw_v;
        m_prev_valid = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic model_clear();
        m_prev_valid = 1'b0;
        m_j1 = 16'h0;
        m_j2 = 16'h0;
    endtask

    task automatic wait_scan(output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < BOUND && !ok) begin
            @(negedge clk);
            cycles++;
            if (scan_done) ok = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] p);
        int cyc;
        bit ok;
        pattern = p;
        predict(p);
        wait_scan(cyc, ok);
        checkOutput("scan_seen", 32'(ok), 32'd1);
        if (ok) checkOutput("scan_period", 32'(cyc), 32'(PERIOD));
    endtask

    task automatic check_idle_outputs(input string tag);
        checkOutput({tag, "_joy_clk"},   32'(joy_clk),   32'd0);
        checkOutput({tag, "_joy_load"},  32'(joy_load),  32'd1);
        checkOutput({tag, "_joystick1"}, 32'(joystick1), 32'd0);
        checkOutput({tag, "_joystick2"}, 32'(joystick2), 32'd0);
        checkOutput({tag, "_scan_done"}, 32'(scan_done), 32'd0);
        checkOutput({tag, "_frame_ok"},  32'(frame_ok),  32'd0);
    endtask

    // Monitor: pops the scoreboard on each scan_done and audits the pin waveform of that scan
    always @(negedge clk) begin
        if (!sys_reset || !enable) begin
            load_lo  = 0;
            clk_rise = 0;
            overlap  = 1'b0;
        end else begin
            if (!joy_load) load_lo++;
            if (joy_clk && !mon_last_clk) clk_rise++;
            if (joy_clk && !joy_load) overlap = 1'b1;
            if (frame_ok && !scan_done) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL frame_ok_alone: got frame_ok=1 with scan_done=0, required both together");
            end
            if (scan_done) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_scan_done: got scan_done=1, required no scan");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("frame_ok",  32'(frame_ok),  32'(e.fok));
                    checkOutput("joystick1", 32'(joystick1), 32'(e.j1));
                    checkOutput("joystick2", 32'(joystick2), 32'(e.j2));
                end
                checkOutput("load_low_cycles", 32'(load_lo),  32'(DIV));
                checkOutput("clk_rises",       32'(clk_rise), 32'(NBITS));
                checkOutput("clk_load_overlap", 32'(overlap), 32'd0);
                load_lo  = 0;
                clk_rise = 0;
                overlap  = 1'b0;
            end
        end
        mon_last_clk = joy_clk;
    end

    initial begin
        logic [31:0] p;
        logic [31:0] prev_p;
        int   rises;
        int   guard;
        logic last_clk;

        sys_reset = 1'b0;
        enable    = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        sys_reset = 1'b1;

        applyStimulus(32'hFFFF_FFFF);
        applyStimulus(32'hFFFF_FFFF);

        p = ~((32'd1 << BIT_RIGHT) | (32'd1 << (16 + BIT_A)));
        applyStimulus(p);
        applyStimulus(p);

        for (int i = 0; i < 4; i++) begin
            applyStimulus((i % 2 == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
        end

        prev_p = 32'hFFFF_FFFF;
        for (int i = 0; i < 8; i++) begin
            p = ($urandom_range(0, 1) == 1) ? prev_p : $urandom;
            applyStimulus(p);
            prev_p = p;
        end

        // Abort a scan part way through the shift, around bit 17
        p = $urandom;
        pattern = p;
        predict(p);
        rises = 0;
        guard = 0;
        last_clk = joy_clk;
        while (rises < 17 && guard < BOUND) begin
            @(negedge clk);
            guard++;
            if (joy_clk && !last_clk) rises++;
            last_clk = joy_clk;
        end
        checkOutput("abort_reached_bit17", 32'(rises), 32'd17);
        repeat (DIV + 1) @(negedge clk);
        enable = 1'b0;
        void'(exp_q.pop_back());
        model_clear();
        @(negedge clk);
        check_idle_outputs("disable");
        repeat (5) begin
            @(negedge clk);
            checkOutput("disable_scan_done", 32'(scan_done), 32'd0);
        end
        enable = 1'b1;
        applyStimulus(p);
        applyStimulus(p);

        // Asynchronous reset while joy_clk is high
        p = $urandom;
        pattern = p;
        predict(p);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!joy_clk && guard < BOUND);
        checkOutput("reached_shift_hi", 32'(joy_clk), 32'd1);
        #2 sys_reset = 1'b0;
        #1 check_idle_outputs("async_reset");
        void'(exp_q.pop_back());
        model_clear();
        repeat (3) @(negedge clk);
        sys_reset = 1'b1;
        applyStimulus(p);
        applyStimulus(p);
        applyStimulus(~p);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
